nmr_bstrm_arb_encoder: RTL and testbench

// Inverse of the arbitrary bitstream generator datapath. Samples a serial bitstream on IN and

---
 rtl/nmr_bstrm_arb_encoder.sv | 210 +++++++++++++++++++++
 tb/tb_nmr_bstrm_arb_encoder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nmr_bstrm_arb_encoder.sv
// Compresses a serial bitstream into generator words {data, pattern, all_1, all_0, eos}
// and buffers them in a first-word-fall-through FIFO.
module nmr_bstrm_arb_encoder #(
    parameter int DATA_WIDTH = 20,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  START,
    input  logic                  STOP,
    input  logic                  IN,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  pattern_mode,
    output logic                  all_1_mode,
    output logic                  all_0_mode,
    output logic                  end_of_sequence,
    output logic                  VALID,
    input  logic                  READY,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  OVERFLOW
);
    localparam int KW = $clog2(DATA_WIDTH + 1);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int WW = DATA_WIDTH + 4;
    localparam logic [DATA_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [KW-1:0] K_LAST = KW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_PAT, S_RUN, S_FLUSH, S_EOS} state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   buffer;
    logic [DATA_WIDTH-1:0]   cnt;
    logic [KW-1:0]           k;
    logic                    level;
    logic                    flush_run;

    logic [DATA_WIDTH-1:0]   shifted;
    logic                    pat_full;
    logic                    shifted_uniform;
    logic [DATA_WIDTH-1:0]   aligned;
    logic                    lead;
    logic                    going;
    logic [KW-1:0]           run_len;
    logic                    push;
    logic [WW-1:0]           word;

    logic [WW-1:0]           mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [CW-1:0]           count;
    logic                    full;
    logic                    pop;
    logic                    do_write;

    assign shifted         = {buffer[DATA_WIDTH-2:0], IN};
    assign pat_full        = (k == K_LAST);
    assign shifted_uniform = (shifted == '0) || (shifted == CNT_MAX);

    // Length of the leading run among the k buffered bits, oldest bit first.
    always_comb begin
        aligned = buffer << (DATA_WIDTH - int'(k));
        lead    = aligned[DATA_WIDTH-1];
        run_len = '0;
        going   = 1'b1;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (going && (i < int'(k)) && (aligned[DATA_WIDTH-1-i] == lead))
                run_len = run_len + KW'(1);
            else
                going = 1'b0;
        end
    end

    always_comb begin
        push = 1'b0;
        word = '0;
        case (state)
            S_PAT: begin
                if (!STOP && pat_full && !shifted_uniform) begin
                    push = 1'b1;
                    word = {shifted, 4'b1000};
                end
            end
            S_RUN: begin
                if (!STOP && !((IN == level) && (cnt != CNT_MAX))) begin
                    push = 1'b1;
                    word = {cnt, 1'b0, level, ~level, 1'b0};
                end
            end
            S_FLUSH: begin
                if (flush_run) begin
                    push = 1'b1;
                    word = {cnt, 1'b0, level, ~level, 1'b0};
                end else if (k != '0) begin
                    push = 1'b1;
                    word = {DATA_WIDTH'(run_len), 1'b0, lead, ~lead, 1'b0};
                end
            end
            S_EOS: begin
                push = 1'b1;
                word = {{DATA_WIDTH{1'b0}}, 4'b0001};
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= S_IDLE;
            buffer    <= '0;
            cnt       <= '0;
            k         <= '0;
            level     <= 1'b0;
            flush_run <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        state     <= S_PAT;
                        BUSY      <= 1'b1;
                        buffer    <= '0;
                        k         <= '0;
                        flush_run <= 1'b0;
                    end
                end
                S_PAT: begin
                    if (STOP) begin
                        state     <= S_FLUSH;
                        flush_run <= 1'b0;
                    end else begin
                        buffer <= shifted;
                        if (pat_full) begin
                            k <= '0;
                            if (shifted_uniform) begin
                                state <= S_RUN;
                                level <= IN;
                                cnt   <= DATA_WIDTH'(DATA_WIDTH);
                            end
                        end else begin
                            k <= k + KW'(1);
                        end
                    end
                end
                S_RUN: begin
                    if (STOP) begin
                        state     <= S_FLUSH;
                        flush_run <= 1'b1;
                    end else if ((IN == level) && (cnt != CNT_MAX)) begin
                        cnt <= cnt + DATA_WIDTH'(1);
                    end else begin
                        state  <= S_PAT;
                        buffer <= DATA_WIDTH'(IN);
                        k      <= KW'(1);
                    end
                end
                S_FLUSH: begin
                    if (flush_run) begin
                        state     <= S_EOS;
                        flush_run <= 1'b0;
                    end else if (k == '0) begin
                        state <= S_EOS;
                    end else begin
                        k <= k - run_len;
                        if (run_len == k) state <= S_EOS;
                    end
                end
                S_EOS: begin
                    state <= S_IDLE;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // A push into a full FIFO only lands if the head is leaving in the same cycle.
    assign VALID    = (count != '0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign pop      = VALID && READY;
    assign do_write = push && (!full || pop);

    always_ff @(posedge CLK) begin
        if (do_write) mem[wr_ptr] <= word;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            OVERFLOW <= 1'b0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_write) - CW'(pop);
            if ((state == S_IDLE) && START)
                OVERFLOW <= 1'b0;
            else if (push && !do_write)
                OVERFLOW <= 1'b1;
        end
    end

    assign {data, pattern_mode, all_1_mode, all_0_mode, end_of_sequence} =
        VALID ? mem[rd_ptr] : '0;
endmodule

// File: tb/tb_nmr_bstrm_arb_encoder.sv
// Bench for nmr_bstrm_arb_encoder: two instances (FIFO depth 8 and 2) compared against
// a chunk-based reference model of the word format.
module tb_nmr_bstrm_arb_encoder;
    localparam int W = 20;
    localparam int MAXC = (1 << W) - 1;
    typedef logic [W+3:0] word_t;

    logic CLK = 1'b0, RST_N = 1'b0, START = 1'b0, STOP = 1'b0, IN = 1'b0;
    logic ready0 = 1'b1, ready1 = 1'b1;
    logic [W-1:0] data0, data1;
    logic pm0, a10, a00, eos0, valid0, busy0, done0, ovf0;
    logic pm1, a11, a01, eos1, valid1, busy1, done1, ovf1;

    int checks = 0, failures = 0;
    int dcnt0 = 0, dcnt1 = 0;
    word_t got0[$], got1[$], expq[$];
    bit stim[$];

    always #5 CLK = ~CLK;

    nmr_bstrm_arb_encoder #(.DATA_WIDTH(W), .FIFO_DEPTH(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .STOP(STOP), .IN(IN),
        .data(data0), .pattern_mode(pm0), .all_1_mode(a10), .all_0_mode(a00),
        .end_of_sequence(eos0), .VALID(valid0), .READY(ready0), .BUSY(busy0),
        .DONE(done0), .OVERFLOW(ovf0));

    nmr_bstrm_arb_encoder #(.DATA_WIDTH(W), .FIFO_DEPTH(2)) dut2 (
        .CLK(CLK), .RST_N(RST_N), .START(START), .STOP(STOP), .IN(IN),
        .data(data1), .pattern_mode(pm1), .all_1_mode(a11), .all_0_mode(a01),
        .end_of_sequence(eos1), .VALID(valid1), .READY(ready1), .BUSY(busy1),
        .DONE(done1), .OVERFLOW(ovf1));

    wire word_t word0 = {data0, pm0, a10, a00, eos0};
    wire word_t word1 = {data1, pm1, a11, a01, eos1};

    // Record every word that transfers at the coming rising edge, plus DONE pulses.
    always @(negedge CLK) begin
        if (valid0 && ready0) got0.push_back(word0);
        if (valid1 && ready1) got1.push_back(word1);
        if (done0) dcnt0++;
        if (done1) dcnt1++;
    end

    function automatic word_t mk_pat(logic [W-1:0] v);
        return {v, 4'b1000};
    endfunction

    function automatic word_t mk_run(bit lvl, int len);
        return {W'(len), 1'b0, lvl, ~lvl, 1'b0};
    endfunction

    // Reference: cut the stream into 20-bit chunks; a uniform chunk grows into a run,
    // a mixed chunk is a pattern, and a short tail splits into maximal runs.
    function automatic void model();
        int n, i, len;
        bit lvl, uniform;
        logic [W-1:0] v;
        expq = {};
        n = stim.size();
        i = 0;
        while (i < n) begin
            if (n - i >= W) begin
                uniform = 1'b1;
                for (int j = 1; j < W; j++) if (stim[i+j] != stim[i]) uniform = 1'b0;
                if (!uniform) begin
                    v = '0;
                    for (int j = 0; j < W; j++) v = {v[W-2:0], stim[i+j]};
                    expq.push_back(mk_pat(v));
                    i += W;
                end else begin
                    lvl = stim[i];
                    len = W;
                    i += W;
                    while (i < n && stim[i] == lvl && len < MAXC) begin
                        len++;
                        i++;
                    end
                    expq.push_back(mk_run(lvl, len));
                end
            end else begin
                lvl = stim[i];
                len = 0;
                while (i < n && stim[i] == lvl) begin
                    len++;
                    i++;
                end
                expq.push_back(mk_run(lvl, len));
            end
        end
        expq.push_back({{W{1'b0}}, 4'b0001});
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic startCapture();
        got0 = {};
        got1 = {};
        dcnt0 = 0;
        dcnt1 = 0;
        START = 1'b1;
        tick();
        START = 1'b0;
        check("busy_after_start", {busy0, busy1}, 2'b11);
    endtask

    task automatic feedBits();
        foreach (stim[i]) begin
            IN = stim[i];
            tick();
        end
    endtask

    task automatic stopCapture(input int drain);
        int n;
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
        IN = 1'b0;
        n = 0;
        while ((busy0 || busy1) && n < 200) begin
            tick();
            n++;
        end
        check("busy_falls_in_time", (n < 200), 1);
        repeat (drain) tick();
    endtask

    task automatic applyStimulus();
        model();
        startCapture();
        feedBits();
        stopCapture(12);
    endtask

    task automatic checkOutput(input string tag, input int n1);
        int e1;
        e1 = (n1 < 0) ? expq.size() : n1;
        check({tag, "_words0"}, got0.size(), expq.size());
        for (int i = 0; i < expq.size() && i < got0.size(); i++)
            check({tag, "_word0"}, got0[i], expq[i]);
        check({tag, "_words1"}, got1.size(), e1);
        for (int i = 0; i < e1 && i < got1.size(); i++)
            check({tag, "_word1"}, got1[i], expq[i]);
        check({tag, "_done"}, {dcnt0, dcnt1}, {32'd1, 32'd1});
        check({tag, "_idle"}, {busy0, busy1, valid0, valid1}, 4'b0000);
    endtask

    initial begin
        logic [W-1:0] pat;
        int nseg, mode, len;

        // Reset state
        repeat (2) tick();
        check("reset_outputs0", {word0, valid0, busy0, done0, ovf0}, '0);
        check("reset_outputs1", {word1, valid1, busy1, done1, ovf1}, '0);
        RST_N = 1'b1;
        tick();

        // Case 1: ten ones
        stim = {};
        repeat (10) stim.push_back(1'b1);
        applyStimulus();
        checkOutput("case1", -1);

        // Case 2: one mixed 20-bit pattern
        stim = {};
        pat = 20'b10100011100011101110;
        for (int i = W - 1; i >= 0; i--) stim.push_back(pat[i]);
        applyStimulus();
        check("case2_model_pattern", expq[0], mk_pat(20'hA38EE));
        checkOutput("case2", -1);

        // Case 3: 30 ones then 25 zeros
        stim = {};
        repeat (30) stim.push_back(1'b1);
        repeat (25) stim.push_back(1'b0);
        applyStimulus();
        checkOutput("case3", -1);

        // Case 4: short tail, then an empty capture
        stim = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        applyStimulus();
        checkOutput("case4a", -1);
        stim = {};
        applyStimulus();
        checkOutput("case4b", -1);

        // Case 5: consumer stalled, depth-2 FIFO drops the terminator
        ready0 = 1'b0;
        ready1 = 1'b0;
        stim = {};
        repeat (30) stim.push_back(1'b1);
        repeat (25) stim.push_back(1'b0);
        applyStimulus();
        check("case5_ovf", {ovf0, ovf1}, 2'b01);
        check("case5_valid", {valid0, valid1}, 2'b11);
        check("case5_head", word1, mk_run(1'b1, 30));
        repeat (3) tick();
        check("case5_head_stable", word1, mk_run(1'b1, 30));
        ready0 = 1'b1;
        ready1 = 1'b1;
        repeat (10) tick();
        checkOutput("case5", 2);
        check("case5_ovf_sticky", ovf1, 1'b1);
        stim = {};
        applyStimulus();
        check("case5_ovf_cleared", ovf1, 1'b0);
        checkOutput("case5b", -1);

        // Case 6: reset in the middle of a run
        startCapture();
        stim = {};
        repeat (25) stim.push_back(1'b1);
        feedBits();
        RST_N = 1'b0;
        #2;
        check("case6_reset", {valid0, valid1, busy0, busy1}, 4'b0000);
        tick();
        RST_N = 1'b1;
        repeat (5) tick();
        check("case6_no_done", dcnt0 + dcnt1, 0);
        check("case6_no_words", got0.size() + got1.size(), 0);
        stim = {};
        repeat (10) stim.push_back(1'b1);
        applyStimulus();
        checkOutput("case6", -1);

        // Randomized streams built from runs and noisy stretches
        for (int t = 0; t < 10; t++) begin
            stim = {};
            nseg = $urandom_range(1, 6);
            for (int s = 0; s < nseg; s++) begin
                mode = $urandom_range(0, 2);
                if (mode < 2) begin
                    len = $urandom_range(1, 45);
                    repeat (len) stim.push_back(mode[0]);
                end else begin
                    len = $urandom_range(1, 25);
                    repeat (len) stim.push_back(1'($urandom_range(0, 1)));
                end
            end
            applyStimulus();
            checkOutput("random", -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
